mc_frame_sched: RTL



---
 rtl/mc_frame_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mc_frame_sched.sv
// rtl/mc_frame_sched.sv - FFT->MULT->IFFT frame scheduler; MC_SCHED_WDOG_EN enables the stall watchdog
module mc_frame_sched #(
    parameter int N        = 256,
    parameter int AW       = 8,
    parameter int MULT_LAT = 0,
    parameter int TIMEOUT  = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          buf_we,
    output logic [AW-1:0] buf_waddr,
    output logic          fft_in_valid,
    input  logic          fft_out_valid,
    output logic [AW-1:0] buf_raddr,
    output logic          mult_valid,
    output logic          ifft_in_valid,
    input  logic          ifft_out_valid,
    output logic          out_valid,
    output logic          frame_done,
    output logic          busy,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_FFT, S_MULT, S_DRAIN, S_DONE
    } state_t;

    localparam logic [AW:0] N_C = (AW+1)'(N);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    generate
        if (MULT_LAT < 0 || MULT_LAT > 3 || TIMEOUT < 2 || N != (1 << AW)) begin : g_param_check
            $error("mc_frame_sched: unsupported parameter combination");
        end
    endgenerate

    state_t      state, state_nxt;
    logic [AW:0] wcnt, rcnt, ocnt;
    logic [AW:0] wcnt_inc, rcnt_inc, ocnt_nxt;
    logic        fft_en, ifft_en;
    logic        in_acc, fft_acc, ocnt_en;
    logic        proto_err, timeout;

    assign in_acc    = in_valid & in_ready;
    assign fft_acc   = fft_out_valid & fft_en;
    assign ocnt_en   = out_valid & (ocnt != N_C);
    assign wcnt_inc  = wcnt + ONE;
    assign rcnt_inc  = rcnt + ONE;
    assign ocnt_nxt  = ocnt_en ? ocnt + ONE : ocnt;

    assign buf_we       = in_acc;
    assign fft_in_valid = in_acc;
    assign buf_waddr    = wcnt[AW-1:0];
    assign buf_raddr    = rcnt[AW-1:0];
    assign out_valid    = ifft_out_valid & ifft_en;

    // Strobes arriving before their stage can use them are dropped and flagged.
    assign proto_err = (fft_out_valid & in_ready)
                     | (ifft_out_valid & (in_ready | (state == S_WAIT_FFT)));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_LOAD: if (in_acc) state_nxt = (wcnt_inc == N_C) ? S_WAIT_FFT : S_LOAD;
            S_WAIT_FFT:     if (fft_out_valid) state_nxt = (rcnt_inc == N_C) ? S_DRAIN : S_MULT;
            S_MULT:         if (fft_out_valid && rcnt_inc == N_C) state_nxt = S_DRAIN;
            S_DRAIN:        if (ocnt_nxt == N_C) state_nxt = S_DONE;
            S_DONE:         state_nxt = S_IDLE;
            default:        state_nxt = S_IDLE;
        endcase
        if (timeout) state_nxt = S_IDLE;
    end

    always_comb begin
        in_ready   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        fft_en     = 1'b0;
        ifft_en    = 1'b0;
        case (state)
            S_IDLE:     begin in_ready = 1'b1; busy = 1'b0; end
            S_LOAD:     in_ready = 1'b1;
            S_WAIT_FFT: fft_en = 1'b1;
            S_MULT:     begin fft_en = 1'b1; ifft_en = 1'b1; end
            S_DRAIN:    ifft_en = 1'b1;
            S_DONE:     frame_done = 1'b1;
            default:    busy = 1'b0;
        endcase
    end

    // Write count wraps at N so the load address is back at 0 while waiting.
    always_ff @(posedge clk) begin
        if (rst || state == S_DONE || timeout) begin
            wcnt <= '0;
            rcnt <= '0;
            ocnt <= '0;
        end else begin
            if (in_acc)  wcnt <= (wcnt_inc == N_C) ? '0 : wcnt_inc;
            if (fft_acc) rcnt <= rcnt_inc;
            ocnt <= ocnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err        <= 1'b0;
            mult_valid <= 1'b0;
        end else begin
            err        <= err | proto_err | timeout;
            mult_valid <= fft_acc;
        end
    end

    generate
        if (MULT_LAT == 0) begin : g_lat0
            assign ifft_in_valid = mult_valid;
        end else begin : g_lat
            logic [MULT_LAT-1:0] lat_sr;
            always_ff @(posedge clk) begin
                if (rst) lat_sr <= '0;
                else     lat_sr <= (lat_sr << 1) | MULT_LAT'(mult_valid);
            end
            assign ifft_in_valid = lat_sr[MULT_LAT-1];
        end
    endgenerate

`ifdef MC_SCHED_WDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt;
    logic           wd_active;

    assign wd_active = (state == S_WAIT_FFT) | (state == S_MULT) | (state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (rst || !wd_active || fft_out_valid || ifft_out_valid) wd_cnt <= '0;
        else                                                      wd_cnt <= wd_cnt + WDW'(1);
    end

    assign timeout = wd_active & ~(fft_out_valid | ifft_out_valid)
                   & (wd_cnt == WDW'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

endmodule
